// File: rtl/lcd_bus_engine.sv
// Write-only HD44780-style LCD bus engine: strobes one command per request onto a
// 4-bit or 8-bit bus with programmable setup/pulse/hold/gap timing and post-command delay.
module lcd_bus_engine #(
  parameter int BUS_8BIT = 0,
  parameter int T_SETUP  = 2,
  parameter int T_PULSE  = 12,
  parameter int T_HOLD   = 1,
  parameter int T_GAP    = 50,
  parameter int T_CMD    = 2000,
  parameter int T_LONG   = 82000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_nib,
  input  logic [7:0] cmd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_d,
  output logic       busy,
  output logic       done
);

  localparam longint MAX_DUR = (longint'(1) << CNT_W) - 1;

  if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_GAP < 1 || T_CMD < 1 || T_LONG < 1 ||
      T_SETUP > MAX_DUR || T_PULSE > MAX_DUR || T_HOLD > MAX_DUR || T_GAP > MAX_DUR ||
      T_CMD > MAX_DUR || T_LONG > MAX_DUR) begin : g_bad_timing
    $error("lcd_bus_engine: timing parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] CMD_M1   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_DELAY = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d, nib_q, nib_d, lo_q, lo_d;
  logic [7:0]       data_q, data_d;
  logic             e_q, e_d, lrs_q, lrs_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]       ld_q, ld_d;
  logic             tick_s, is_long_s, split_s;

  // State, counter, latched command and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      lo_q    <= 1'b0;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
      lrs_q   <= 1'b0;
      ld_q    <= 8'h00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      e_q     <= e_d;
      lrs_q   <= lrs_d;
      ld_q    <= ld_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: every state counts down its duration and leaves when the counter hits zero
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    nib_d     = nib_q;
    lo_d      = lo_q;
    data_d    = data_q;
    tick_s    = (cnt_q == '0);
    cnt_d     = tick_s ? cnt_q : cnt_q - CNT_W'(1);
    // Clear display (0x01) and return home (0x02/0x03) need the long execution time
    is_long_s = !rs_q && (data_q[7:2] == 6'd0);
    split_s   = (BUS_8BIT == 0) && !lo_q && !nib_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_M1;
          rs_d    = cmd_rs;
          nib_d   = cmd_nib;
          data_d  = cmd_data;
          lo_d    = 1'b0;
        end
      end
      S_SETUP: if (tick_s) begin state_d = S_PULSE; cnt_d = PULSE_M1; end
      S_PULSE: if (tick_s) begin state_d = S_HOLD;  cnt_d = HOLD_M1;  end
      S_HOLD: begin
        if (tick_s) begin
          if (split_s) begin
            state_d = S_GAP;
            cnt_d   = GAP_M1;
          end else begin
            state_d = S_DELAY;
            cnt_d   = is_long_s ? LONG_M1 : CMD_M1;
          end
        end
      end
      S_GAP: if (tick_s) begin state_d = S_SETUP; cnt_d = SETUP_M1; lo_d = 1'b1; end
      S_DELAY: if (tick_s) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    e_d     = (state_d == S_PULSE);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DELAY) && (cnt_d == '0);
    if (state_d == S_IDLE) begin
      lrs_d = 1'b0;
      ld_d  = 8'h00;
    end else if (BUS_8BIT != 0) begin
      lrs_d = rs_d;
      ld_d  = data_d;
    end else begin
      lrs_d = rs_d;
      ld_d  = {4'h0, (lo_d ? data_d[3:0] : data_d[7:4])};
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lcd_e     = e_q;
  assign lcd_rs    = lrs_q;
  assign lcd_d     = ld_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: doc/lcd_bus_engine.md
LCD_BUS_ENGINE -- requirements
Module: lcd_bus_engine

Interface
REQ-001 The module SHALL expose parameters (name, default, meaning):
- BUS_8BIT, 0: 1 = 8-bit LCD bus with one transfer per command; 0 = 4-bit bus with high nibble then low nibble.
- T_SETUP, 2: clk cycles from data/RS valid to E rising.
- T_PULSE, 12: clk cycles E is held high.
- T_HOLD, 1: clk cycles data/RS are held after E falls.
- T_GAP, 50: clk cycles between the two nibbles of one command.
- T_CMD, 2000: post-command delay in clk cycles, normal commands.
- T_LONG, 82000: post-command delay in clk cycles, clear/home commands.
- CNT_W, 17: delay counter width.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: engine idle, able to accept a command.
- cmd_rs, in, 1: register select for the command.
- cmd_nib, in, 1: 1 = send the high nibble only (4-bit init sequence); ignored when BUS_8BIT=1.
- cmd_data, in, 8: command or character byte.
- lcd_e, out, 1: LCD enable strobe.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read/write; this block is write-only.
- lcd_d, out, 8: LCD data; in 4-bit mode the nibble is driven on [3:0] and [7:4]=0.
- busy, out, 1: transfer or delay in progress.
- done, out, 1: one-cycle pulse when a command fully completes.

Function
REQ-003 The state machine SHALL have the states IDLE, SETUP, PULSE, HOLD, GAP and DELAY; all outputs SHALL be registered.
REQ-004 A command SHALL be accepted on a clk edge where cmd_valid=1 and cmd_ready=1; cmd_rs, cmd_nib and cmd_data SHALL then be latched, and later input changes SHALL have no effect.
REQ-005 cmd_ready SHALL be 1 only in IDLE; busy SHALL equal the inverse of cmd_ready.
REQ-006 IDLE SHALL go to SETUP on acceptance, otherwise stay in IDLE.
REQ-007 SETUP SHALL last T_SETUP cycles with lcd_e=0, and lcd_rs and lcd_d driven from the latched command.
REQ-008 PULSE SHALL last T_PULSE cycles with lcd_e=1, and lcd_rs and lcd_d unchanged.
REQ-009 HOLD SHALL last T_HOLD cycles with lcd_e=0, and lcd_rs and lcd_d unchanged.
REQ-010 Exit from HOLD SHALL depend on the transfer:
- 4-bit mode, first nibble, cmd_nib=0: go to GAP, which lasts T_GAP cycles with lcd_e=0, then to SETUP with the low nibble.
- Otherwise: go to DELAY.
REQ-011 In 4-bit mode the first nibble SHALL be cmd_data[7:4] and the second cmd_data[3:0]; in 8-bit mode lcd_d SHALL be cmd_data in a single transfer.
REQ-012 DELAY SHALL last T_LONG cycles when cmd_rs=0 and cmd_data[7:2]=0 (clear/home), and T_CMD cycles otherwise; lcd_e SHALL be 0 throughout.
REQ-013 done SHALL be 1 exactly in the last cycle of DELAY; the next state SHALL be IDLE, with cmd_ready=1 in the following cycle.
REQ-014 In IDLE, lcd_rs=0 and lcd_d=0.
REQ-015 lcd_rw SHALL be 0 at all times.
REQ-016 A single CNT_W-bit down-counter SHALL be loaded with (duration-1) on each state entry; the state advances when the counter is 0.
REQ-017 All timing parameters SHALL be >=1; if a duration exceeds 2^CNT_W-1, elaboration SHALL fail.
REQ-018 cmd_valid while busy SHALL be ignored and not queued.
REQ-019 Back-to-back commands SHALL be accepted no earlier than the first cycle cmd_ready=1 after done.

Reset
REQ-020 reset=1 SHALL force IDLE immediately, including mid-transfer, with:
- lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0;
- done=0, busy=0, cmd_ready=1;
- counter and latched command cleared.
REQ-021 After reset deasserts, the first edge with cmd_valid=1 SHALL be accepted.

Verification
REQ-022 4-bit mode with defaults, accept cmd_rs=1, cmd_data=0x41 at edge t0 -> the bench SHALL check:
- lcd_d=0x4 from t0+1, lcd_e=1 during cycles t0+3..t0+14;
- lcd_d=0x1 from t0+66, lcd_e=1 during cycles t0+68..t0+79;
- done=1 at t0+2080, cmd_ready=1 at t0+2081.
REQ-023 cmd_rs=0, cmd_data=0x01 -> DELAY SHALL last 82000 cycles and done=1 at t0+82080; cmd_data=0x28 -> the normal 2000-cycle delay SHALL apply.
REQ-024 cmd_nib=1, cmd_data=0x30 -> a single E pulse with lcd_d=0x3, no GAP, and done=1 at t0+15+2000.
REQ-025 BUS_8BIT=1, cmd_data=0xA5 -> one E pulse with lcd_d=0xA5 and done=1 at t0+2015.
REQ-026 cmd_valid held high during busy -> exactly one acceptance per command; assert reset during PULSE -> lcd_e=0 and cmd_ready=1 at the next sample, with no done pulse.
